// File: rtl/elevator_scheduler.sv
// elevator_scheduler: request latch, direction-holding floor selection and engine/door
// sequencing for a three-floor cab. Optional macro DOOR_REOPEN_EN restarts the door timer.
module elevator_scheduler #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic       FRQ,
    input  logic       RST,
    input  logic [2:0] interior_panel,
    input  logic [2:0] exterior_panel,
    output logic [1:0] engine,
    output logic [2:0] doors,
    output logic [1:0] current_floor,
    output logic [2:0] pending
);
    localparam int unsigned MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                       : DOOR_CYCLES;
    localparam int unsigned TW = $clog2(MAX_CYCLES) + 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] DOWN = 2'd2;
    localparam logic [1:0] OPEN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    floor_q, floor_d;
    logic [2:0]    pending_q, pending_d;
    logic          dir_up_q, dir_up_d;

    logic [2:0] buttons, req;
    logic [1:0] next_floor;
    logic       here_idle, above_idle, below_idle;
    logic       hit_next, above_next, below_next;
    logic       restart;

    // Idle decisions use registered requests only; arrival decisions also see this cycle's
    // presses so a press latched on the arrival edge still stops the cab.
    always_comb begin
        buttons    = interior_panel | exterior_panel;
        req        = pending_q | buttons;
        next_floor = (state_q == DOWN) ? floor_q - 2'd1 : floor_q + 2'd1;
        here_idle  = 1'b0;
        above_idle = 1'b0;
        below_idle = 1'b0;
        hit_next   = 1'b0;
        above_next = 1'b0;
        below_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (pending_q[i]) begin
                if (2'(i) == floor_q) here_idle = 1'b1;
                if (2'(i) > floor_q)  above_idle = 1'b1;
                if (2'(i) < floor_q)  below_idle = 1'b1;
            end
            if (req[i]) begin
                if (2'(i) == next_floor) hit_next = 1'b1;
                if (2'(i) > next_floor)  above_next = 1'b1;
                if (2'(i) < next_floor)  below_next = 1'b1;
            end
        end
    end

`ifdef DOOR_REOPEN_EN
    logic here_press;

    always_comb begin
        here_press = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (buttons[i] && (2'(i) == floor_q)) here_press = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        restart  = 1'b0;
        case (state_q)
            IDLE: begin
                if (here_idle) begin
                    state_d = OPEN;
                end else if (above_idle && (dir_up_q || !below_idle)) begin
                    state_d  = UP;
                    dir_up_d = 1'b1;
                end else if (below_idle) begin
                    state_d  = DOWN;
                    dir_up_d = 1'b0;
                end
            end
            UP, DOWN: begin
                if (timer_q == TRAVEL_LAST) begin
                    floor_d = next_floor;
                    if (hit_next) begin
                        state_d = OPEN;
                    end else if ((state_q == UP) ? above_next : below_next) begin
                        restart = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OPEN: begin
`ifdef DOOR_REOPEN_EN
                if (here_press) begin
                    restart = 1'b1;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = IDLE;
                end
`else
                if (timer_q == DOOR_LAST) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || restart) begin
            timer_d = '0;
        end else if (state_q == IDLE) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // Requests for the floor whose doors are open (or opening this edge) are absorbed.
        for (int i = 0; i < 3; i++) begin
            pending_d[i] = req[i];
            if (state_q == OPEN && 2'(i) == floor_q) pending_d[i] = 1'b0;
            if (state_d == OPEN && 2'(i) == floor_d) pending_d[i] = 1'b0;
        end
    end

    always_ff @(posedge FRQ) begin
        if (RST) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            floor_q   <= 2'd0;
            pending_q <= 3'b000;
            dir_up_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
        end
    end

    always_comb begin
        engine = (state_q == UP) ? 2'b01 : (state_q == DOWN) ? 2'b10 : 2'b00;
        for (int i = 0; i < 3; i++) begin
            doors[i] = (state_q == OPEN) && (2'(i) == floor_q);
        end
        current_floor = floor_q;
        pending       = pending_q;
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: table-driven per-cycle vectors plus directed door-reopen and
// mid-travel reset sequences for elevator_scheduler (default 8/4 cycle timing).
module tb_elevator_scheduler;
    logic       FRQ = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] interior_panel = 3'b000;
    logic [2:0] exterior_panel = 3'b000;
    logic [1:0] engine;
    logic [2:0] doors;
    logic [1:0] current_floor;
    logic [2:0] pending;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    elevator_scheduler #(
        .TRAVEL_CYCLES(8),
        .DOOR_CYCLES  (4)
    ) dut (
        .FRQ           (FRQ),
        .RST           (RST),
        .interior_panel(interior_panel),
        .exterior_panel(exterior_panel),
        .engine        (engine),
        .doors         (doors),
        .current_floor (current_floor),
        .pending       (pending)
    );

    always #5 FRQ = ~FRQ;

    typedef struct {
        logic [2:0] ip;
        logic [2:0] ep;
        logic [1:0] eng;
        logic [2:0] dr;
        logic [1:0] fl;
        logic [2:0] pd;
    } vec_t;

    vec_t vecs[$];

    function automatic void push_n(input int n, input logic [2:0] ip, input logic [2:0] ep,
                                   input logic [1:0] eng, input logic [2:0] dr,
                                   input logic [1:0] fl, input logic [2:0] pd);
        vec_t v;
        v.ip  = ip;
        v.ep  = ep;
        v.eng = eng;
        v.dr  = dr;
        v.fl  = fl;
        v.pd  = pd;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] ip, input logic [2:0] ep);
        interior_panel = ip;
        exterior_panel = ep;
        @(posedge FRQ);
        #1;
    endtask

    // Engine and doors must never be active together; illegal codes never appear.
    always @(negedge FRQ) begin
        if (mon_en) begin
            checks++;
            if ((engine != 2'b00 && doors != 3'b000) || engine == 2'b11 ||
                current_floor == 2'd3 || !$onehot0(doors)) begin
                errors++;
                $display("FAIL exclusivity: engine=%b doors=%b floor=%0d", engine, doors,
                         current_floor);
            end
        end
    end

    initial begin
        logic open_seen;
        int   open_cnt;
        int   exp_open;

        RST = 1'b1;
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);
        check("reset_engine", 32'(engine), 32'h0);
        check("reset_doors", 32'(doors), 32'h0);
        check("reset_floor", 32'(current_floor), 32'h0);
        check("reset_pending", 32'(pending), 32'h0);
        RST    = 1'b0;
        mon_en = 1'b1;

        // Single stop at floor 0.
        push_n(1, 3'b001, 3'b000, 2'b00, 3'b000, 2'd0, 3'b001);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b001, 2'd0, 3'b000);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd0, 3'b000);
        // Two-floor trip 0 -> 2 without stopping.
        push_n(1, 3'b100, 3'b000, 2'b00, 3'b000, 2'd0, 3'b100);
        push_n(8, 3'b000, 3'b000, 2'b01, 3'b000, 2'd0, 3'b100);
        push_n(8, 3'b000, 3'b000, 2'b01, 3'b000, 2'd1, 3'b100);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b100, 2'd2, 3'b000);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd2, 3'b000);
        // 2 -> 0, with floor 1 pressed exactly on the arrival edge.
        push_n(1, 3'b001, 3'b000, 2'b00, 3'b000, 2'd2, 3'b001);
        push_n(8, 3'b000, 3'b000, 2'b10, 3'b000, 2'd2, 3'b001);
        push_n(1, 3'b010, 3'b000, 2'b00, 3'b010, 2'd1, 3'b001);
        push_n(3, 3'b000, 3'b000, 2'b00, 3'b010, 2'd1, 3'b001);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd1, 3'b001);
        push_n(8, 3'b000, 3'b000, 2'b10, 3'b000, 2'd1, 3'b001);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b001, 2'd0, 3'b000);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd0, 3'b000);
        // dir is down at floor 0; only an upward request exists, so go up to 1.
        push_n(1, 3'b010, 3'b000, 2'b00, 3'b000, 2'd0, 3'b010);
        push_n(8, 3'b000, 3'b000, 2'b01, 3'b000, 2'd0, 3'b010);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b010, 2'd1, 3'b000);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd1, 3'b000);
        // Parked at 1 with dir up, 101 pressed: up to 2 first, then down to 0.
        push_n(1, 3'b101, 3'b000, 2'b00, 3'b000, 2'd1, 3'b101);
        push_n(8, 3'b000, 3'b000, 2'b01, 3'b000, 2'd1, 3'b101);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b100, 2'd2, 3'b001);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd2, 3'b001);
        push_n(8, 3'b000, 3'b000, 2'b10, 3'b000, 2'd2, 3'b001);
        push_n(8, 3'b000, 3'b000, 2'b10, 3'b000, 2'd1, 3'b001);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b001, 2'd0, 3'b000);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd0, 3'b000);
        // 0 -> 2 with a hall call for floor 1 during the first floor's travel.
        push_n(1, 3'b100, 3'b000, 2'b00, 3'b000, 2'd0, 3'b100);
        push_n(2, 3'b000, 3'b000, 2'b01, 3'b000, 2'd0, 3'b100);
        push_n(1, 3'b000, 3'b010, 2'b01, 3'b000, 2'd0, 3'b110);
        push_n(5, 3'b000, 3'b000, 2'b01, 3'b000, 2'd0, 3'b110);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b010, 2'd1, 3'b100);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd1, 3'b100);
        push_n(8, 3'b000, 3'b000, 2'b01, 3'b000, 2'd1, 3'b100);
        push_n(4, 3'b000, 3'b000, 2'b00, 3'b100, 2'd2, 3'b000);
        push_n(1, 3'b000, 3'b000, 2'b00, 3'b000, 2'd2, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ip, vecs[i].ep);
            check($sformatf("vec%0d {eng,doors,floor,pend}", i),
                  32'({engine, doors, current_floor, pending}),
                  32'({vecs[i].eng, vecs[i].dr, vecs[i].fl, vecs[i].pd}));
        end

        // Door reopen: go 2 -> 1, press floor 1 so it is sampled entering open cycle 3.
        step(3'b010, 3'b000);
        open_seen = 1'b0;
        for (int i = 0; i < 40 && !open_seen; i++) begin
            step(3'b000, 3'b000);
            if (doors == 3'b010) open_seen = 1'b1;
        end
        check("reopen_reach", 32'(open_seen), 32'h1);
        open_cnt = open_seen ? 1 : 0;
        step(3'b000, 3'b000);
        if (doors == 3'b010) open_cnt++;
        step(3'b010, 3'b000);
        if (doors == 3'b010) open_cnt++;
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 3'b000);
            if (doors == 3'b010) open_cnt++;
        end
`ifdef DOOR_REOPEN_EN
        exp_open = 6;
`else
        exp_open = 4;
`endif
        check("reopen_open_cycles", 32'(open_cnt), 32'(exp_open));
        check("reopen_pending", 32'(pending), 32'h0);
        check("reopen_idle", 32'({engine, current_floor}), 32'({2'b00, 2'd1}));

        // Reset during travel 1 -> 2, with a press held during the reset edge.
        step(3'b100, 3'b000);
        step(3'b000, 3'b000);
        check("mid_up_engine", 32'(engine), 32'h1);
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);
        RST = 1'b1;
        step(3'b010, 3'b000);
        check("rst_mid_engine", 32'(engine), 32'h0);
        check("rst_mid_doors", 32'(doors), 32'h0);
        check("rst_mid_floor", 32'(current_floor), 32'h0);
        check("rst_mid_pending", 32'(pending), 32'h0);
        RST = 1'b0;
        step(3'b000, 3'b000);
        check("post_rst_idle", 32'({engine, doors, pending}), 32'h0);
        step(3'b001, 3'b000);
        check("post_rst_latch", 32'(pending), 32'h1);
        open_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(3'b000, 3'b000);
            if (i == 0) check("post_rst_doors", 32'(doors), 32'h1);
            if (doors == 3'b001) open_cnt++;
            if (engine != 2'b00) open_cnt = open_cnt + 100;
        end
        check("post_rst_open_cycles", 32'(open_cnt), 32'd4);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
